// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: holds decoded instruction state for EX and applies
// operand forwarding on the registered register-file data.
module id_ex_reg #(
  parameter logic [3:0] NOP_ALU_OP = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [3:0]  id_alu_op,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_use_imm,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_is_branch,
  input  logic [1:0]  fwd_a,
  input  logic [1:0]  fwd_b,
  input  logic [31:0] exmem_result,
  input  logic [31:0] memwb_result,
  output logic        ex_valid,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_in_1,
  output logic [31:0] alu_in_2,
  output logic [31:0] ex_rs2_fwd,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_is_branch
);

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        use_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        is_branch;
  } stage_t;

  localparam stage_t Bubble = '{alu_op: NOP_ALU_OP, default: '0};

  stage_t stage_q, load_d;
  logic [31:0] op_a;

  // Side-effecting control bits only survive with a real instruction.
  always_comb begin
    load_d           = '0;
    load_d.valid     = id_valid;
    load_d.alu_op    = id_alu_op;
    load_d.rs1_data  = id_rs1_data;
    load_d.rs2_data  = id_rs2_data;
    load_d.imm       = id_imm;
    load_d.pc        = id_pc;
    load_d.rs1       = id_rs1;
    load_d.rs2       = id_rs2;
    load_d.rd        = id_rd;
    load_d.use_imm   = id_use_imm;
    load_d.reg_write = id_valid & id_reg_write;
    load_d.mem_read  = id_valid & id_mem_read;
    load_d.mem_write = id_valid & id_mem_write;
    load_d.is_branch = id_valid & id_is_branch;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= Bubble;
    end else if (flush) begin
      stage_q <= Bubble;
    end else if (!stall) begin
      stage_q <= load_d;
    end
  end

  always_comb begin
    case (fwd_a)
      2'b01:   op_a = exmem_result;
      2'b10:   op_a = memwb_result;
      default: op_a = stage_q.rs1_data;
    endcase
  end

  always_comb begin
    case (fwd_b)
      2'b01:   ex_rs2_fwd = exmem_result;
      2'b10:   ex_rs2_fwd = memwb_result;
      default: ex_rs2_fwd = stage_q.rs2_data;
    endcase
  end

  assign alu_in_1     = op_a;
  assign alu_in_2     = stage_q.use_imm ? stage_q.imm : ex_rs2_fwd;
  assign ex_valid     = stage_q.valid;
  assign alu_op       = stage_q.alu_op;
  assign ex_pc        = stage_q.pc;
  assign ex_imm       = stage_q.imm;
  assign ex_rs1       = stage_q.rs1;
  assign ex_rs2       = stage_q.rs2;
  assign ex_rd        = stage_q.rd;
  assign ex_reg_write = stage_q.reg_write;
  assign ex_mem_read  = stage_q.mem_read;
  assign ex_mem_write = stage_q.mem_write;
  assign ex_is_branch = stage_q.is_branch;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: directed scenarios plus a randomized
// stall/flush/forwarding run checked against a reference model.
module tb_id_ex_reg;

  localparam logic [3:0] ADD = 4'h0;
  localparam logic [3:0] SUB = 4'h1;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, id_valid;
  logic [3:0]  id_alu_op;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_imm, id_reg_write, id_mem_read, id_mem_write, id_is_branch;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid;
  logic [3:0]  alu_op;
  logic [31:0] alu_in_1, alu_in_2, ex_rs2_fwd, ex_pc, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] in1, in2, rs2f, pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw, br;
  } obs_t;

  obs_t obs, exp_v;
  obs_t sb[$];
  int checks = 0;
  int errors = 0;

  assign obs = {ex_valid, alu_op, alu_in_1, alu_in_2, ex_rs2_fwd, ex_pc, ex_imm,
                ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch};

  id_ex_reg #(.NOP_ALU_OP(ADD)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_alu_op(id_alu_op), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_imm(id_use_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_is_branch(id_is_branch), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .exmem_result(exmem_result), .memwb_result(memwb_result), .ex_valid(ex_valid),
    .alu_op(alu_op), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .ex_rs2_fwd(ex_rs2_fwd),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_is_branch(ex_is_branch)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(logic v, logic [3:0] op, logic [31:0] in1, in2, rs2f, pc, imm,
                              logic [4:0] rs1, rs2, rd, logic rw, mr, mw, br);
    mk = {v, op, in1, in2, rs2f, pc, imm, rs1, rs2, rd, rw, mr, mw, br};
  endfunction

  function automatic logic [31:0] fwd_sel(logic [1:0] sel, logic [31:0] raw);
    if (sel == 2'b01) return exmem_result;
    if (sel == 2'b10) return memwb_result;
    return raw;
  endfunction

  task automatic set_id(input logic v, input logic [3:0] op, input logic [31:0] r1d, r2d, imm,
                        pc, input logic [4:0] a, b, d, input logic ui, rw, mr, mw, br);
    id_valid = v; id_alu_op = op; id_rs1_data = r1d; id_rs2_data = r2d; id_imm = imm;
    id_pc = pc; id_rs1 = a; id_rs2 = b; id_rd = d; id_use_imm = ui;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_is_branch = br;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 reset = 1'b0;
    #1;
    sb.push_back(mk(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_async: got %h expected %h", obs, exp_v); end
    set_id(1, SUB, 32'h1, 32'h2, 32'h3, 32'h4, 1, 2, 3, 1, 1, 1, 1, 1);
    sb.push_back(mk(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick;
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_hold_load: got %h expected %h", obs, exp_v); end
    stall = 1'b1; flush = 1'b1;
    sb.push_back(mk(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick;
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_hold_ctrl: got %h expected %h", obs, exp_v); end
    stall = 1'b0; flush = 1'b0;
    #2 reset = 1'b1;
  endtask

  task automatic test_load;
    set_id(1, SUB, 32'd10, 32'd3, 32'h55, 32'h40, 1, 2, 3, 0, 1, 0, 0, 0);
    sb.push_back(mk(1, SUB, 32'd10, 32'd3, 32'd3, 32'h40, 32'h55, 1, 2, 3, 1, 0, 0, 0));
    tick;
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL load: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_forward;
    logic [31:0] a_tab [4] = '{32'h5, 32'h100, 32'h200, 32'h5};
    logic [31:0] b_tab [4] = '{32'h33, 32'h100, 32'h200, 32'h33};
    set_id(1, ADD, 32'h5, 32'h33, 32'h0, 32'h44, 4, 5, 6, 0, 1, 0, 0, 0);
    exmem_result = 32'h100; memwb_result = 32'h200;
    for (int s = 0; s < 4; s++) begin
      fwd_a = 2'(s); fwd_b = 2'(3 - s);
      sb.push_back(mk(1, ADD, a_tab[s], b_tab[3-s], b_tab[3-s], 32'h44, 0, 4, 5, 6, 1, 0, 0, 0));
      if (s == 0) tick; else #1;
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL forward_sel%0d: got %h expected %h", s, obs, exp_v); end
    end
    fwd_a = 2'b00; fwd_b = 2'b00;
  endtask

  task automatic test_imm;
    set_id(1, ADD, 32'h12, 32'h99, 32'hFFFF_FFFC, 32'h80, 7, 8, 9, 1, 1, 0, 0, 0);
    fwd_b = 2'b01; exmem_result = 32'd7;
    sb.push_back(mk(1, ADD, 32'h12, 32'hFFFF_FFFC, 32'd7, 32'h80, 32'hFFFF_FFFC, 7, 8, 9,
                    1, 0, 0, 0));
    tick;
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL immediate: got %h expected %h", obs, exp_v); end
    fwd_b = 2'b00;
  endtask

  task automatic test_stall_flush;
    obs_t held;
    set_id(1, SUB, 32'h1, 32'h2, 32'h3, 32'h100, 10, 11, 9, 0, 1, 0, 0, 0);
    held = mk(1, SUB, 32'h1, 32'h2, 32'h2, 32'h100, 32'h3, 10, 11, 9, 1, 0, 0, 0);
    sb.push_back(held);
    tick;
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL stall_preload: got %h expected %h", obs, exp_v); end
    stall = 1'b1;
    set_id(1, ADD, 32'd77, 32'd88, 32'd99, 32'h200, 1, 1, 1, 1, 0, 1, 1, 1);
    for (int i = 0; i < 2; i++) begin
      sb.push_back(held);
      tick;
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, obs, exp_v); end
    end
    flush = 1'b1;
    sb.push_back(mk(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick;
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL flush_over_stall: got %h expected %h", obs, exp_v); end
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_invalid;
    set_id(0, SUB, 32'h11, 32'h22, 32'h33, 32'h44, 1, 2, 3, 0, 1, 1, 1, 1);
    sb.push_back(mk(0, SUB, 32'h11, 32'h22, 32'h22, 32'h44, 32'h33, 1, 2, 3, 0, 0, 0, 0));
    tick;
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL invalid_load: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_async_reset;
    obs_t ld;
    set_id(1, SUB, 32'hA, 32'hB, 32'hC, 32'hD, 1, 2, 3, 0, 1, 0, 1, 0);
    ld = mk(1, SUB, 32'hA, 32'hB, 32'hB, 32'hD, 32'hC, 1, 2, 3, 1, 0, 1, 0);
    sb.push_back(ld);
    tick;
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL async_preload: got %h expected %h", obs, exp_v); end
    #2 reset = 1'b0;
    #1;
    sb.push_back(mk(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL async_clear: got %h expected %h", obs, exp_v); end
    sb.push_back(mk(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick;
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL async_hold: got %h expected %h", obs, exp_v); end
    #2 reset = 1'b1;
    sb.push_back(ld);
    tick;
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL async_resume: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_back_to_back;
    logic mv, mui, mrw, mmr, mmw, mbr;
    logic [3:0] mop;
    logic [31:0] m1, m2, mimm, mpc, f2;
    logic [4:0] ma, mb, md;
    for (int i = 0; i < 40; i++) begin
      set_id(1'($urandom), 4'($urandom), $urandom, $urandom, $urandom, $urandom,
             5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
      stall = ($urandom_range(0, 3) == 0);
      flush = (i == 0) || ($urandom_range(0, 7) == 0);
      fwd_a = 2'($urandom); fwd_b = 2'($urandom);
      exmem_result = $urandom; memwb_result = $urandom;
      if (flush) begin
        {mv, mui, mrw, mmr, mmw, mbr} = '0; mop = ADD;
        {m1, m2, mimm, mpc} = '0; {ma, mb, md} = '0;
      end else if (!stall) begin
        mv = id_valid; mop = id_alu_op; m1 = id_rs1_data; m2 = id_rs2_data;
        mimm = id_imm; mpc = id_pc; ma = id_rs1; mb = id_rs2; md = id_rd; mui = id_use_imm;
        mrw = id_valid & id_reg_write; mmr = id_valid & id_mem_read;
        mmw = id_valid & id_mem_write; mbr = id_valid & id_is_branch;
      end
      f2 = fwd_sel(fwd_b, m2);
      sb.push_back(mk(mv, mop, fwd_sel(fwd_a, m1), mui ? mimm : f2, f2, mpc, mimm,
                      ma, mb, md, mrw, mmr, mmw, mbr));
      tick;
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random_edge%0d: got %h expected %h", i, obs, exp_v); end
      fwd_a = 2'($urandom); fwd_b = 2'($urandom);
      f2 = fwd_sel(fwd_b, m2);
      sb.push_back(mk(mv, mop, fwd_sel(fwd_a, m1), mui ? mimm : f2, f2, mpc, mimm,
                      ma, mb, md, mrw, mmr, mmw, mbr));
      #1;
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random_fwd%0d: got %h expected %h", i, obs, exp_v); end
    end
    stall = 1'b0; flush = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fwd_a = 2'b00; fwd_b = 2'b00; exmem_result = '0; memwb_result = '0;
    test_reset;
    test_load;
    test_forward;
    test_imm;
    test_stall_flush;
    test_invalid;
    test_async_reset;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter NOP_ALU_OP, default `ADD (from alu_def.v), meaning alu_op value driven for a bubble.
REQ-002 SHALL have clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have stall  input  1  hold current contents (hazard unit).
REQ-005 SHALL have flush  input  1  replace next contents with bubble (branch/jump redirect).
REQ-006 SHALL have id_valid  input  1  ID stage holds a real instruction.
REQ-007 SHALL have id_alu_op  input  4  ALU operation code per alu_def.v.
REQ-008 SHALL have id_rs1_data, id_rs2_data, id_imm, id_pc  input  32 each  decoded operands, immediate, PC.
REQ-009 SHALL have id_rs1, id_rs2, id_rd  input  5 each  register indices.
REQ-010 SHALL have id_use_imm, id_reg_write, id_mem_read, id_mem_write, id_is_branch  input  1 each  control bits.
REQ-011 SHALL have fwd_a, fwd_b  input  2 each  forwarding selects for operand 1 / operand 2.
REQ-012 SHALL have exmem_result, memwb_result  input  32 each  forwarding sources.
REQ-013 SHALL have ex_valid  output  1  EX-stage instruction is real.
REQ-014 SHALL have alu_op  output  4  to ALU.
REQ-015 SHALL have alu_in_1, alu_in_2  output  32 each  to ALU.
REQ-016 SHALL have ex_rs2_fwd  output  32  forwarded rs2 value for store data.
REQ-017 SHALL have ex_pc, ex_imm  output  32 each; ex_rs1, ex_rs2, ex_rd  output  5 each; ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch  output  1 each  registered copies.

Function
REQ-018 SHALL register all ex_* fields, alu_op, and raw rs1/rs2 data on the rising edge of clk; latency one cycle from ID inputs to outputs.
REQ-019 SHALL apply per-edge priority: reset > flush > stall > load.
REQ-020 SHALL on load capture all ID inputs; ex_valid <= id_valid.
REQ-021 SHALL on stall (flush=0) keep every register unchanged, including ex_valid.
REQ-022 SHALL on flush load a bubble: ex_valid=0, alu_op=NOP_ALU_OP, ex_rd=0, ex_rs1=0, ex_rs2=0, all control bits 0, data fields 0, regardless of stall.
REQ-023 SHALL force ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch to 0 when loading with id_valid=0.
REQ-024 SHALL compute operand A combinationally: fwd_a 00 -> registered rs1 data, 01 -> exmem_result, 10 -> memwb_result, 11 -> registered rs1 data.
REQ-025 SHALL compute ex_rs2_fwd identically using fwd_b and registered rs2 data.
REQ-026 SHALL drive alu_in_1 = operand A; alu_in_2 = ex_imm when registered use_imm=1, else ex_rs2_fwd.
REQ-027 SHALL pass forwarding data unmodified (32-bit, no extension or truncation).
REQ-028 SHALL ignore fwd_a/fwd_b for register state; they affect only combinational outputs in the same cycle.

Reset
REQ-029 SHALL on reset=0 immediately (no clock) clear ex_valid and all control bits, set alu_op=NOP_ALU_OP, all data and index registers to 0.
REQ-030 SHALL hold reset state while reset=0 irrespective of stall, flush, clk.
REQ-031 SHALL resume normal loading on the first rising clk edge after reset returns to 1.

Verification
REQ-032 Load: id_alu_op=`SUB, rs1_data=10, rs2_data=3, use_imm=0, fwd 00, id_valid=1 -> next cycle alu_op=`SUB, alu_in_1=10, alu_in_2=3, ex_valid=1.
REQ-033 Forwarding: registered rs1=5, exmem_result=0x100, memwb_result=0x200; fwd_a=01 -> alu_in_1=0x100; fwd_a=10 -> 0x200; fwd_a=11 -> 5, same cycle.
REQ-034 Immediate: use_imm=1, imm=0xFFFFFFFC, fwd_b=01, exmem_result=7 -> alu_in_2=0xFFFFFFFC, ex_rs2_fwd=7.
REQ-035 Stall then flush: load rd=9, reg_write=1; stall 2 cycles -> outputs unchanged; stall=1 with flush=1 -> bubble (ex_valid=0, ex_rd=0, reg_write=0, alu_op=NOP_ALU_OP).
REQ-036 Invalid load: id_valid=0, id_reg_write=1, id_mem_write=1 -> ex_valid=0, ex_reg_write=0, ex_mem_write=0.
REQ-037 Async reset mid-operation: pulse reset=0 between clk edges while ex_valid=1 -> outputs clear before next edge; first edge after release loads ID inputs.
